// File: rtl/irq_pending_latch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pending_latch_pkg
//  Purpose  : Shared constants and FSM state encoding for the interrupt
//             pending latch that feeds the 4-to-2 priority encoder.
//  Contents :
//    IRQ_N     - default number of request lines (power of 2, >= 2)
//    IRQ_SYNC  - default synchroniser depth per line (>= 2)
//    state_e   - 2-bit handshake FSM state codes
//  Revision : 1.0 - initial release
// ============================================================================
package irq_pending_latch_pkg;

    localparam int IRQ_N    = 4;
    localparam int IRQ_SYNC = 2;

    // Handshake FSM state codes. The encoding is fixed so that the state
    // value can be observed and compared directly in debug tooling.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage : irq_pending_latch_pkg
`default_nettype wire

// File: rtl/irq_pending_latch_sync.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pending_latch_sync
//  Purpose  : Per-line multi-flop synchroniser followed by a rising-edge
//             detector. Each request line passes through SYNC_STAGES flops,
//             then a "previous" flop; an event is reported for one cycle
//             when the synchronised value is 1 and the previous value is 0.
//  Ports    :
//    clk       in   1   rising-edge clock
//    rst_n     in   1   asynchronous active-low reset
//    irq_in_i  in   N   asynchronous request lines
//    rise_o    out  N   one-cycle rising-edge indication per line
//  Revision : 1.0 - initial release
// ============================================================================
module irq_pending_latch_sync
    import irq_pending_latch_pkg::*;
#(
    parameter int N           = IRQ_N,
    parameter int SYNC_STAGES = IRQ_SYNC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_in_i,
    output logic [N-1:0] rise_o
);

    // Stage 0 samples the raw asynchronous input; stage SYNC_STAGES-1 is
    // the first value considered safe to use in synchronous logic.
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  prev_q;

    // All stages clear on reset, so a line that is held high across reset
    // release is seen as a fresh 0->1 transition and yields one event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : irq_pending_latch_sync
`default_nettype wire

// File: rtl/irq_pending_latch.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pending_latch
//  Purpose  : Upstream stage of the 4-to-2 priority encoder. Synchronises
//             N asynchronous request lines, latches each rising edge into a
//             pending register, presents the masked pending vector to the
//             encoder and runs a request/acknowledge handshake with the
//             consumer, which returns the serviced index for clearing.
//  Ports    :
//    clk       in   1          rising-edge clock
//    rst_n     in   1          asynchronous active-low reset
//    irq_in    in   N          asynchronous request lines, rising edge = event
//    mask      in   N          1 = line enabled (synchronous to clk)
//    ack       in   1          one-cycle pulse: consumer serviced ack_idx
//    ack_idx   in   log2(N)    index being acknowledged (encoder {x,y})
//    clr_lost  in   1          one-cycle pulse: clears lost[]
//    pend_o    out  N          pend & mask, drives encoder D input
//    irq_req   out  1          request to consumer, high while in REQ
//    lost      out  N          sticky: edge arrived on an already pending bit
//    ack_err   out  1          one-cycle pulse: ack rejected
//  Revision : 1.0 - initial release
// ============================================================================
module irq_pending_latch
    import irq_pending_latch_pkg::*;
#(
    parameter int N           = IRQ_N,
    parameter int SYNC_STAGES = IRQ_SYNC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         irq_in,
    input  logic [N-1:0]         mask,
    input  logic                 ack,
    input  logic [$clog2(N)-1:0] ack_idx,
    input  logic                 clr_lost,
    output logic [N-1:0]         pend_o,
    output logic                 irq_req,
    output logic [N-1:0]         lost,
    output logic                 ack_err
);

    // ------------------------------------------------------------------
    // Synchroniser and edge detector
    // ------------------------------------------------------------------
    logic [N-1:0] rise;

    irq_pending_latch_sync #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in_i (irq_in),
        .rise_o   (rise)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;
    logic [N-1:0] lost_q;
    logic [N-1:0] lost_d;
    state_e       state_q;
    logic         irq_req_q;
    logic         ack_err_q;

    // ------------------------------------------------------------------
    // Acknowledge decode
    // ------------------------------------------------------------------
    // The accepted-ack test uses the raw pending bit, not the masked one:
    // a bit that is pending but masked is still a legal target.
    logic         ack_hit;
    logic         ack_ok;
    logic [N-1:0] clr_vec;

    assign ack_hit = pend_q[ack_idx];
    assign ack_ok  = ack && (state_q == ST_REQ) && ack_hit;

    always_comb begin
        clr_vec = '0;
        if (ack_ok) begin
            clr_vec[ack_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending and lost next-state
    // ------------------------------------------------------------------
    // A new edge always wins over a clear on the same bit, and in that
    // case the event is not lost: the pending bit simply stays set for
    // the new occurrence.
    logic [N-1:0] lost_set;

    always_comb begin
        pend_d   = rise | (pend_q & ~clr_vec);
        lost_set = rise & pend_q & ~clr_vec;
        // A set in the same cycle as clr_lost takes priority.
        lost_d   = lost_set | (clr_lost ? '0 : lost_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            lost_q <= '0;
        end else begin
            pend_q <= pend_d;
            lost_q <= lost_d;
        end
    end

    // Purely combinational from pend and mask, so unmasking a pending bit
    // shows on the encoder input without waiting for a clock.
    assign pend_o = pend_q & mask;

    // ------------------------------------------------------------------
    // Handshake FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            irq_req_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ack) begin
                        ack_err_q <= 1'b1;
                    end
                    if (|pend_o) begin
                        state_q   <= ST_REQ;
                        irq_req_q <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (ack) begin
                        if (ack_hit) begin
                            state_q   <= ST_HOLD;
                            irq_req_q <= 1'b0;
                        end else begin
                            ack_err_q <= 1'b1;
                        end
                    end else if (pend_o == '0) begin
                        // Everything pending has been masked away.
                        state_q   <= ST_IDLE;
                        irq_req_q <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    // One quiet cycle lets the encoder and consumer see
                    // the vector with the serviced bit removed.
                    if (ack) begin
                        ack_err_q <= 1'b1;
                    end
                    state_q   <= ST_IDLE;
                    irq_req_q <= 1'b0;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req = irq_req_q;
    assign ack_err = ack_err_q;
    assign lost    = lost_q;

endmodule : irq_pending_latch
`default_nettype wire
